// File: rtl/h2f_gpio_pkg.sv
// Shared constants and types for the HPS lightweight-bridge GPIO bank.
package h2f_gpio_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] REG_IN   = 2'd0;
  localparam logic [1:0] REG_OUT  = 2'd1;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // Expand Avalon byte enables into a per-bit write mask.
  function automatic logic [DATA_W-1:0] byte_mask(input logic [3:0] be);
    byte_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/h2f_gpio_debounce.sv
// One GPIO input channel: 2-FF synchroniser plus stability counter.
// H2F_GPIO_DEBOUNCE_EN builds the counter; otherwise the synchroniser output is registered straight through.
module h2f_gpio_debounce
`ifdef H2F_GPIO_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 250000
)
`endif
(
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_q, sync_d;
  logic       db_q, db_d;

  // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
    end
  end

`ifdef H2F_GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sync_d = {sync_q[0], din};
    prev_d = sync_q[1];
    cnt_d  = '0;
    db_d   = db_q;
    // Count only while the sample is steady and disagrees with the accepted value.
    if (sync_q[1] == prev_q && sync_q[1] != db_q) begin
      if (cnt_q == CNT_LAST) db_d = sync_q[1];
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end
`else
  always_comb begin
    sync_d = {sync_q[0], din};
    db_d   = sync_q[1];
  end
`endif

  assign dout = db_q;

endmodule

// File: rtl/h2f_lw_gpio_bank.sv
// GPIO bank on the HPS-to-FPGA lightweight bridge: debounced inputs with edge capture/irq, registered outputs.
// Build option: define H2F_GPIO_DEBOUNCE_EN to include the per-channel debounce counters.
module h2f_lw_gpio_bank
  import h2f_gpio_pkg::*;
#(
  parameter int                 NUM_IN          = 4,
  parameter int                 NUM_OUT         = 4,
  parameter int                 DEBOUNCE_CYCLES = 250000,
  parameter int                 EDGE_MODE       = 0,
  parameter logic [NUM_OUT-1:0] OUT_RESET       = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [DATA_W-1:0]  avs_writedata,
  input  logic [3:0]         avs_byteenable,
  output logic [DATA_W-1:0]  avs_readdata,
  output logic               avs_readdatavalid,
  input  logic [NUM_IN-1:0]  gpio_in,
  output logic [NUM_OUT-1:0] gpio_out,
  output logic               irq
);

  localparam edge_mode_e MODE = edge_mode_e'(2'(EDGE_MODE));

  if (NUM_IN < 1 || NUM_IN > DATA_W || NUM_OUT < 1 || NUM_OUT > DATA_W ||
      DEBOUNCE_CYCLES < 2 || EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_param_check
    $error("h2f_lw_gpio_bank: parameter out of range");
  end

  logic [NUM_IN-1:0]  db, db_prev_q, db_prev_d, cap, w1c;
  logic [NUM_IN-1:0]  mask_q, mask_d, edge_q, edge_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d, lanes, wbits;
  logic               rvalid_q, rvalid_d, irq_q, irq_d;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    h2f_gpio_debounce
`ifdef H2F_GPIO_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (gpio_in[i]),
        .dout    (db[i])
      );
  end

  always_comb begin
    lanes     = byte_mask(avs_byteenable);
    wbits     = avs_writedata & lanes;
    db_prev_d = db;
    case (MODE)
      EDGE_FALL: cap = ~db & db_prev_q;
      EDGE_BOTH: cap = db ^ db_prev_q;
      default:   cap = db & ~db_prev_q;
    endcase

    out_d  = out_q;
    mask_d = mask_q;
    w1c    = '0;
    if (avs_write) begin
      case (avs_address)
        REG_OUT:  out_d  = (out_q & ~lanes[NUM_OUT-1:0]) | wbits[NUM_OUT-1:0];
        REG_MASK: mask_d = (mask_q & ~lanes[NUM_IN-1:0]) | wbits[NUM_IN-1:0];
        REG_EDGE: w1c    = wbits[NUM_IN-1:0];
        default:  ;
      endcase
    end
    // A capture in the same cycle as its W1C survives.
    edge_d = (edge_q & ~w1c) | cap;
    irq_d  = |(edge_q & mask_q);

    // Reads see the registers as they were before any same-cycle write.
    rvalid_d = avs_read;
    rdata_d  = '0;
    if (avs_read) begin
      case (avs_address)
        REG_IN:   rdata_d = DATA_W'(db);
        REG_OUT:  rdata_d = DATA_W'(out_q);
        REG_MASK: rdata_d = DATA_W'(mask_q);
        default:  rdata_d = DATA_W'(edge_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_prev_q <= '0;
      out_q     <= OUT_RESET;
      mask_q    <= '0;
      edge_q    <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      db_prev_q <= db_prev_d;
      out_q     <= out_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Upper data bits go unused when the channel counts are below 32.
  logic unused_bits;
  assign unused_bits = ^{avs_writedata, lanes, wbits};

  assign gpio_out          = out_q;
  assign irq               = irq_q;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;

endmodule
